// File: rtl/count_capture_monitor_pkg.sv
// rtl/count_capture_monitor_pkg.sv - shared types and default widths for the count capture monitor
package count_capture_monitor_pkg;

   localparam int DEF_N      = 7;
   localparam int DEF_WRAP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_CAPTURED = 2'd2
   } state_t;

endpackage

// File: rtl/count_capture_monitor_rise_detect.sv
// rtl/count_capture_monitor_rise_detect.sv - registered copy of a level plus rising-edge strobe
module count_capture_monitor_rise_detect (
   input  logic clock,
   input  logic clear_n,
   input  logic d,
   output logic rise
);

   logic r_d;

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_d <= 1'b0;
      end else begin
         r_d <= d;
      end
   end

   assign rise = d & ~r_d;

endmodule

// File: rtl/count_capture_monitor.sv
// rtl/count_capture_monitor.sv - wrap/match pulse generator and arm/trigger snapshot of a count bus
module count_capture_monitor
   import count_capture_monitor_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int WRAP_W = DEF_WRAP_W
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic [0:N]        count_in,
   input  logic [0:N]        compare,
   input  logic              arm,
   input  logic              trig,
   input  logic              ack,
   output logic              match_pulse,
   output logic              wrap_pulse,
   output logic              busy,
   output logic              capture_valid,
   output logic [0:N]        capture_value,
   output logic [WRAP_W-1:0] capture_wraps
);

   localparam logic [WRAP_W-1:0] W_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [0:N]        r_count_q;
   logic              r_primed;
   logic [WRAP_W-1:0] r_wraps;
   logic [WRAP_W-1:0] w_wraps_nxt;
   logic              w_trig_rise;
   logic              w_wrap;
   logic              w_restart;
   logic              w_match;
   logic              w_capture;

   count_capture_monitor_rise_detect u_trig_rise (
      .clock   (clock),
      .clear_n (clear_n),
      .d       (trig),
      .rise    (w_trig_rise)
   );

   // r_primed masks the first post-reset sample, where r_count_q is not a real history value
   assign w_wrap    = r_primed && (r_count_q == '1) && (count_in == '0);
   assign w_restart = r_primed && (count_in < r_count_q) && !w_wrap;
   assign w_match   = r_primed && (count_in == compare) && (count_in != r_count_q);

   always_comb begin
      w_state_nxt = r_state;
      w_wraps_nxt = r_wraps;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (arm) begin
               w_state_nxt = ST_ARMED;
               w_wraps_nxt = '0;
            end
         end
         ST_ARMED: begin
            if (w_restart) begin
               w_wraps_nxt = '0;
            end else if (w_wrap && !(&r_wraps)) begin
               w_wraps_nxt = r_wraps + W_ONE;
            end
            if (w_trig_rise) begin
               w_state_nxt = ST_CAPTURED;
               w_capture   = 1'b1;
            end
         end
         ST_CAPTURED: begin
            if (ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_count_q     <= '0;
         r_primed      <= 1'b0;
         r_wraps       <= '0;
         match_pulse   <= 1'b0;
         wrap_pulse    <= 1'b0;
         capture_valid <= 1'b0;
         capture_value <= '0;
         capture_wraps <= '0;
      end else begin
         r_count_q   <= count_in;
         r_primed    <= 1'b1;
         r_wraps     <= w_wraps_nxt;
         match_pulse <= w_match;
         wrap_pulse  <= w_wrap;
         // Snapshot takes the updated wrap count so a same-cycle wrap is included
         if (w_capture) begin
            capture_value <= count_in;
            capture_wraps <= w_wraps_nxt;
            capture_valid <= 1'b1;
         end else if (r_state == ST_CAPTURED && ack) begin
            capture_valid <= 1'b0;
         end
      end
   end

   assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_count_capture_monitor.sv
// tb/tb_count_capture_monitor.sv - self-checking bench with behavioural reference model
module tb_count_capture_monitor;

   logic       clock = 1'b0;
   logic       clear_n;
   logic [0:7] count_in;
   logic [0:7] compare;
   logic       arm;
   logic       trig;
   logic       ack;
   logic       match_pulse;
   logic       wrap_pulse;
   logic       busy;
   logic       capture_valid;
   logic [0:7] capture_value;
   logic [3:0] capture_wraps;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;

   // model state
   int m_prev = 0, m_trig_prev = 0, m_primed = 0, m_mode = 0, m_wraps = 0;
   int e_match = 0, e_wrap = 0, e_valid = 0, e_val = 0, e_cw = 0;

   count_capture_monitor dut (
      .clock         (clock),
      .clear_n       (clear_n),
      .count_in      (count_in),
      .compare       (compare),
      .arm           (arm),
      .trig          (trig),
      .ack           (ack),
      .match_pulse   (match_pulse),
      .wrap_pulse    (wrap_pulse),
      .busy          (busy),
      .capture_valid (capture_valid),
      .capture_value (capture_value),
      .capture_wraps (capture_wraps)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // mode: 0 idle, 1 waiting for trigger, 2 holding a snapshot
   always @(posedge clock) begin
      int cur, cmpv;
      bit w, rs, rise;
      cur  = int'(count_in);
      cmpv = int'(compare);
      if (!clear_n) begin
         m_prev = 0; m_trig_prev = 0; m_primed = 0; m_mode = 0; m_wraps = 0;
         e_match = 0; e_wrap = 0; e_valid = 0; e_val = 0; e_cw = 0;
      end else begin
         w    = m_primed && m_prev == 255 && cur == 0;
         rs   = m_primed && cur < m_prev && !w;
         rise = trig && !m_trig_prev;
         e_wrap  = w;
         e_match = m_primed && cur == cmpv && cur != m_prev;
         if (m_mode == 0) begin
            if (arm) begin m_mode = 1; m_wraps = 0; end
         end else if (m_mode == 1) begin
            if (rs) m_wraps = 0;
            else if (w) m_wraps = (m_wraps + 1 > 15) ? 15 : m_wraps + 1;
            if (rise) begin m_mode = 2; e_val = cur; e_cw = m_wraps; e_valid = 1; end
         end else if (ack) begin
            m_mode = 0; e_valid = 0;
         end
         m_prev = cur; m_trig_prev = int'(trig); m_primed = 1;
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         check("match_pulse", match_pulse, e_match);
         check("wrap_pulse", wrap_pulse, e_wrap);
         check("busy", busy, m_mode != 0);
         check("capture_valid", capture_valid, e_valid);
         check("capture_value", capture_value, e_val);
         check("capture_wraps", capture_wraps, e_cw);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic do_wrap();
      count_in = 8'h80; tick();
      count_in = 8'hFF; tick();
      count_in = 8'h00; tick();
   endtask

   initial begin
      int pulses;
      clear_n = 0; count_in = 8'h55; compare = 8'h55; arm = 1; trig = 0; ack = 0;
      // 1. reset with busy inputs
      tick();
      cmp_en = 1;
      for (int i = 0; i < 2; i++) begin
         trig = ~trig; tick();
         check("rst_outputs", {match_pulse, wrap_pulse, busy, capture_valid}, 4'b0000);
         check("rst_value", {capture_value, capture_wraps}, 12'h000);
      end
      clear_n = 1; arm = 0; trig = 0; tick();
      check("no_pulse_after_release", match_pulse, 1'b0);
      tick();

      // 2. wrap with compare 0
      compare = 8'h00;
      count_in = 8'hFE; tick();
      count_in = 8'hFF; tick();
      check("wrap_not_early", wrap_pulse, 1'b0);
      count_in = 8'h00; tick();
      check("wrap_pulse", wrap_pulse, 1'b1);
      check("wrap_match_same", match_pulse, 1'b1);
      tick();
      check("wrap_one_cycle", wrap_pulse, 1'b0);

      // 3. held match pulses once
      compare = 8'h10; count_in = 8'h0F; tick();
      count_in = 8'h10; pulses = 0;
      for (int i = 0; i < 5; i++) begin tick(); pulses += int'(match_pulse); end
      check("match_hold_count", pulses, 1);

      // 4. capture after three wraps
      arm = 1; tick(); arm = 0;
      check("armed_busy", busy, 1'b1);
      for (int i = 0; i < 3; i++) do_wrap();
      count_in = 8'h29; tick();
      count_in = 8'h2A; trig = 1; tick(); trig = 0;
      check("cap_value", capture_value, 8'h2A);
      check("cap_wraps", capture_wraps, 4'd3);
      check("cap_valid", capture_valid, 1'b1);
      do_wrap();
      check("cap_held", capture_value, 8'h2A);
      ack = 1; tick(); ack = 0;
      check("ack_idle", {busy, capture_valid}, 2'b00);
      check("ack_retain", capture_value, 8'h2A);

      // 5. saturation then restart
      arm = 1; tick(); arm = 0;
      for (int i = 0; i < 20; i++) do_wrap();
      count_in = 8'h33; trig = 1; tick(); trig = 0;
      check("sat_wraps", capture_wraps, 4'd15);
      ack = 1; tick(); ack = 0;
      arm = 1; tick(); arm = 0;
      do_wrap(); do_wrap();
      count_in = 8'h80; tick();
      count_in = 8'h00; tick();
      check("restart_no_wrap", wrap_pulse, 1'b0);
      do_wrap();
      count_in = 8'h10; trig = 1; tick(); trig = 0;
      check("restart_wraps", capture_wraps, 4'd1);
      ack = 1; tick(); ack = 0;

      // 6. collisions
      arm = 1; trig = 1; tick(); arm = 0;
      check("arm_trig_busy", busy, 1'b1);
      tick(); tick();
      check("trig_held_no_cap", capture_valid, 1'b0);
      trig = 0; tick();
      trig = 1; tick();
      check("fresh_edge_cap", capture_valid, 1'b1);
      ack = 1; arm = 1; tick(); ack = 0;
      check("ack_arm_idle", {busy, capture_valid}, 2'b00);
      tick(); arm = 0;
      check("rearm_next", busy, 1'b1);
      trig = 0; tick(); trig = 1; tick(); trig = 0;
      check("cap_again", capture_valid, 1'b1);
      clear_n = 0; tick(); clear_n = 1;
      check("reset_drops_cap", {busy, capture_valid}, 2'b00);

      // random phase
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 65)      count_in = count_in + 8'd1;
         else if (r < 78) count_in = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hFE;
         else if (r < 90) count_in = count_in;
         else             count_in = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 49) == 0) compare = 8'($urandom_range(0, 255));
         arm     = ($urandom_range(0, 9) == 0);
         trig    = ($urandom_range(0, 3) == 0) ? ~trig : trig;
         ack     = ($urandom_range(0, 7) == 0);
         clear_n = ($urandom_range(0, 199) != 0);
         tick();
      end
      clear_n = 1;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
